// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 800x600@60 timing constants and sequencer state type
package vga_pkg;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;

  // The line starts with the blanking interval; the visible area is at the end.
  localparam int H_TOTAL      = VGA_H_FP + VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE;
  localparam int V_TOTAL      = VGA_V_FP + VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE;
  localparam int H_DISP_START = VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_DISP_START = VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// rtl/vga_frame_sequencer_if.sv - upstream grayscale pixel valid/ready handshake
interface vga_frame_sequencer_if #(
  parameter int BIT_DEPTH = 8
) ();

  logic [BIT_DEPTH-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - raster position counters with hold-at-origin and region decode
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int ROWS     = 512,
  parameter int COLS     = 512,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic hsync,
  output logic vsync,
  output logic window,
  output logic frame_origin,
  output logic frame_wrap,
  output logic last_pixel
);

  localparam logic [10:0] H_LAST   = 11'(H_FP + H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_FP + V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [10:0] HS_BEGIN = 11'(H_FP);
  localparam logic [10:0] HS_END   = 11'(H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEGIN = 10'(V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_FP + V_SYNC);
  localparam logic [10:0] WIN_X0   = 11'(H_FP + H_SYNC + H_BP);
  localparam logic [10:0] WIN_X1   = 11'(H_FP + H_SYNC + H_BP + COLS);
  localparam logic [9:0]  WIN_Y0   = 10'(V_FP + V_SYNC + V_BP);
  localparam logic [9:0]  WIN_Y1   = 10'(V_FP + V_SYNC + V_BP + ROWS);

  logic [10:0] cx;
  logic [9:0]  cy;

  // Without enable the position is pinned to the origin so a new frame starts at (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (!en) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == H_LAST) begin
      cx <= '0;
      cy <= (cy == V_LAST) ? '0 : cy + 10'd1;
    end else begin
      cx <= cx + 11'd1;
    end
  end

  assign hsync        = (cx >= HS_BEGIN) && (cx < HS_END);
  assign vsync        = (cy >= VS_BEGIN) && (cy < VS_END);
  assign window       = (cx >= WIN_X0) && (cx < WIN_X1) && (cy >= WIN_Y0) && (cy < WIN_Y1);
  assign frame_origin = (cx == '0) && (cy == '0);
  assign frame_wrap   = (cx == H_LAST) && (cy == V_LAST);
  assign last_pixel   = (cx == WIN_X1 - 11'd1) && (cy == WIN_Y1 - 10'd1);

endmodule

// File: rtl/vga_frame_sequencer.sv
// rtl/vga_frame_sequencer.sv - VGA frame sequencing, windowed pixel pull and aligned output registers
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int ROWS      = 512,
  parameter int COLS      = 512,
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  vga_frame_sequencer_if.slave  pix,
  output logic [BIT_DEPTH-1:0]  R,
  output logic [BIT_DEPTH-1:0]  G,
  output logic [BIT_DEPTH-1:0]  B,
  output logic                  HS,
  output logic                  VS,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  underflow
);

  seq_state_t           state_q, state_d;
  logic                 hsync, vsync, window, frame_origin, frame_wrap, last_pixel;
  logic                 xfer;
  logic [BIT_DEPTH-1:0] pix_q;

  vga_timing_counter #(
    .ROWS(ROWS), .COLS(COLS),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (busy),
    .hsync        (hsync),
    .vsync        (vsync),
    .window       (window),
    .frame_origin (frame_origin),
    .frame_wrap   (frame_wrap),
    .last_pixel   (last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Start has priority in IDLE; once running, only stop matters, and only once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)      state_d = RUN;
      RUN:       if (stop)       state_d = STOP_PEND;
      STOP_PEND: if (frame_wrap) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign pix.pix_ready = busy && window;
  assign xfer          = pix.pix_ready && pix.pix_valid;

  // Pixel, syncs and pulses share one register stage so they stay aligned at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q       <= '0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (pix.pix_ready && !pix.pix_valid) underflow <= 1'b1;
      if (!busy) begin
        pix_q       <= '0;
        HS          <= 1'b1;
        VS          <= 1'b1;
        frame_start <= 1'b0;
        frame_done  <= 1'b0;
      end else begin
        pix_q       <= xfer ? pix.pix_data : '0;
        HS          <= ~hsync;
        VS          <= ~vsync;
        frame_start <= frame_origin;
        frame_done  <= last_pixel;
      end
    end
  end

  assign R = pix_q;
  assign G = pix_q;
  assign B = pix_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// tb/tb_vga_frame_sequencer.sv - bench for vga_frame_sequencer at full and reduced raster sizes
module tb_vga_frame_sequencer;

  localparam int F_HT    = 1056;
  localparam int S_HFP   = 3,  S_HSYNC = 5, S_HBP = 4, S_HACT = 32;
  localparam int S_VFP   = 1,  S_VSYNC = 2, S_VBP = 2, S_VACT = 20;
  localparam int S_ROWS  = 12, S_COLS  = 16;
  localparam int S_HT    = S_HFP + S_HSYNC + S_HBP + S_HACT;
  localparam int S_VT    = S_VFP + S_VSYNC + S_VBP + S_VACT;
  localparam int S_HDS   = S_HFP + S_HSYNC + S_HBP;
  localparam int S_VDS   = S_VFP + S_VSYNC + S_VBP;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int F_NMAX  = 29 * F_HT + 5;

  typedef struct {
    int n; int hs; int vs; int rdy; int fs; int r;
  } fvec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       f_rst_n, f_start, f_stop;
  logic [7:0] f_R, f_G, f_B;
  logic       f_HS, f_VS, f_fs, f_fd, f_busy, f_uf;
  logic       s_rst_n, s_start, s_stop;
  logic [7:0] s_R, s_G, s_B;
  logic       s_HS, s_VS, s_fs, s_fd, s_busy, s_uf;

  vga_frame_sequencer_if #(.BIT_DEPTH(8)) f_if ();
  vga_frame_sequencer_if #(.BIT_DEPTH(8)) s_if ();

  vga_frame_sequencer u_full (
    .clk(clk), .rst_n(f_rst_n), .start(f_start), .stop(f_stop), .pix(f_if),
    .R(f_R), .G(f_G), .B(f_B), .HS(f_HS), .VS(f_VS), .frame_start(f_fs),
    .frame_done(f_fd), .busy(f_busy), .underflow(f_uf)
  );

  vga_frame_sequencer #(
    .BIT_DEPTH(8), .ROWS(S_ROWS), .COLS(S_COLS),
    .H_ACTIVE(S_HACT), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_ACTIVE(S_VACT), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP)
  ) u_dut (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .stop(s_stop), .pix(s_if),
    .R(s_R), .G(s_G), .B(s_B), .HS(s_HS), .VS(s_VS), .frame_start(s_fs),
    .frame_done(s_fd), .busy(s_busy), .underflow(s_uf)
  );

  int    checks = 0, failures = 0;
  int    seg_err = 0;
  string seg_msg = "";
  bit    m_busy = 0, m_pend = 0, m_uf = 0;
  int    m_pos = 0;
  int    dut_xfers = 0, m_xfers = 0, fd_cnt = 0, ready_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic seg_fail(input string msg);
    if (seg_err == 0) seg_msg = msg;
    seg_err++;
  endtask

  task automatic seg_check(input string name);
    checks++;
    if (seg_err != 0) begin
      failures++;
      $display("FAIL %s: %0d mismatching cycles, expected 0; first: %s", name, seg_err, seg_msg);
    end
    seg_err = 0;
  endtask

  // One clock of the reduced DUT against the raster model; called and returns at a negedge.
  task automatic s_step(input bit st, input bit sp, input bit vld, input logic [7:0] d);
    int cx, cy;
    bit win, e_hs, e_vs, e_fs, e_fd;
    logic [7:0] e_r;
    s_start = st; s_stop = sp; s_if.pix_valid = vld; s_if.pix_data = d;
    cx = m_pos % S_HT;
    cy = m_pos / S_HT;
    win = m_busy && cx >= S_HDS && cx < S_HDS + S_COLS && cy >= S_VDS && cy < S_VDS + S_ROWS;
    #1;
    if (s_if.pix_ready !== win)
      seg_fail($sformatf("pix_ready at (%0d,%0d) got %b want %b", cx, cy, s_if.pix_ready, win));
    if (s_if.pix_ready === 1'b1) ready_cnt++;
    if (s_if.pix_ready === 1'b1 && vld) dut_xfers++;
    if (win && vld) m_xfers++;
    e_r  = (win && vld) ? d : 8'd0;
    e_hs = !(m_busy && cx >= S_HFP && cx < S_HFP + S_HSYNC);
    e_vs = !(m_busy && cy >= S_VFP && cy < S_VFP + S_VSYNC);
    e_fs = m_busy && m_pos == 0;
    e_fd = m_busy && cx == S_HDS + S_COLS - 1 && cy == S_VDS + S_ROWS - 1;
    if (win && !vld) m_uf = 1;
    if (!m_busy) begin
      if (st) m_busy = 1;
    end else if (m_pend && m_pos == S_FRAME - 1) begin
      m_busy = 0; m_pend = 0; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % S_FRAME;
      if (sp) m_pend = 1;
    end
    @(posedge clk);
    @(negedge clk);
    if (s_R !== e_r || s_G !== e_r || s_B !== e_r || s_HS !== e_hs || s_VS !== e_vs ||
        s_fs !== e_fs || s_fd !== e_fd || s_busy !== m_busy || s_uf !== m_uf)
      seg_fail($sformatf("after (%0d,%0d): RGB=%0d/%0d/%0d want %0d HS=%b/%b VS=%b/%b fs=%b/%b fd=%b/%b busy=%b/%b uf=%b/%b",
               cx, cy, s_R, s_G, s_B, e_r, s_HS, e_hs, s_VS, e_vs, s_fs, e_fs, s_fd, e_fd,
               s_busy, m_busy, s_uf, m_uf));
    if (s_fd === 1'b1) fd_cnt++;
  endtask

  task automatic clear_counts();
    dut_xfers = 0; m_xfers = 0; fd_cnt = 0; ready_cnt = 0;
  endtask

  initial begin
    fvec_t ftab[19];
    int ti, hs_low, hs_first, vs_low, rdy27, rdy28, rgb_bad, steps, p0;

    // n = clocks since the start edge; counters sit at cx = n, outputs reflect n-1.
    ftab = '{
      '{0,     1, 1, 0, 0, 0},   '{1,     1, 1, 0, 1, 0},   '{2,     1, 1, 0, 0, 0},
      '{40,    1, 1, 0, 0, 0},   '{41,    0, 1, 0, 0, 0},   '{168,   0, 1, 0, 0, 0},
      '{169,   1, 1, 0, 0, 0},   '{1056,  1, 1, 0, 0, 0},   '{1057,  1, 0, 0, 0, 0},
      '{1096,  1, 0, 0, 0, 0},   '{1097,  0, 0, 0, 0, 0},   '{5280,  1, 0, 0, 0, 0},
      '{5281,  1, 1, 0, 0, 0},   '{29823, 1, 1, 0, 0, 0},   '{29824, 1, 1, 1, 0, 0},
      '{29869, 1, 1, 1, 0, 44},  '{30335, 1, 1, 1, 0, 254}, '{30336, 1, 1, 0, 0, 255},
      '{30337, 1, 1, 0, 0, 0}
    };

    f_rst_n = 0; f_start = 0; f_stop = 0; f_if.pix_valid = 1; f_if.pix_data = 0;
    s_rst_n = 0; s_start = 0; s_stop = 0; s_if.pix_valid = 0; s_if.pix_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_R", s_R, 0);           chk("rst_G", s_G, 0);          chk("rst_B", s_B, 0);
    chk("rst_HS", s_HS, 1);         chk("rst_VS", s_VS, 1);        chk("rst_busy", s_busy, 0);
    chk("rst_ready", s_if.pix_ready, 0);
    chk("rst_fs", s_fs, 0);         chk("rst_fd", s_fd, 0);        chk("rst_uf", s_uf, 0);
    chk("rst_full_HS", f_HS, 1);    chk("rst_full_VS", f_VS, 1);   chk("rst_full_busy", f_busy, 0);
    f_rst_n = 1; s_rst_n = 1;
    @(negedge clk);

    // Full-size raster: table of exact positions plus per-line statistics.
    f_start = 1;
    @(posedge clk);
    @(negedge clk);
    f_start = 0;
    ti = 0; hs_low = 0; hs_first = -1; vs_low = 0; rdy27 = 0; rdy28 = 0; rgb_bad = 0;
    for (int n = 0; n <= F_NMAX; n++) begin
      f_if.pix_data = 8'(n % F_HT);
      #1;
      if (ti < 19 && ftab[ti].n == n) begin
        chk($sformatf("full_n%0d_HS", n), f_HS, ftab[ti].hs);
        chk($sformatf("full_n%0d_VS", n), f_VS, ftab[ti].vs);
        chk($sformatf("full_n%0d_ready", n), f_if.pix_ready, ftab[ti].rdy);
        chk($sformatf("full_n%0d_fs", n), f_fs, ftab[ti].fs);
        chk($sformatf("full_n%0d_R", n), f_R, ftab[ti].r);
        ti++;
      end
      if (n >= 1 && n <= F_HT && f_HS === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (n >= 1 && n <= 6000 && f_VS === 1'b0) vs_low++;
      if (n >= 27 * F_HT && n < 28 * F_HT && f_if.pix_ready === 1'b1) rdy27++;
      if (n >= 28 * F_HT && n < 29 * F_HT && f_if.pix_ready === 1'b1) rdy28++;
      if (f_R !== f_G || f_R !== f_B) rgb_bad++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("full_table_entries_hit", ti, 19);
    chk("full_hs_low_cycles", hs_low, 128);
    chk("full_hs_first_low", hs_first, 41);
    chk("full_vs_low_cycles", vs_low, 4 * F_HT);
    chk("full_ready_line27", rdy27, 0);
    chk("full_ready_line28", rdy28, 512);
    chk("full_rgb_equal", rgb_bad, 0);
    chk("full_underflow", f_uf, 0);

    // Reduced raster: stop is ignored while idle.
    repeat (5) s_step(0, 1, 1, 8'h5a);
    seg_check("idle_stop_ignored");

    // Frame 1: always-valid incrementing byte source.
    clear_counts();
    s_step(1, 0, 1, 8'd0);
    for (int i = 0; i < S_FRAME; i++) s_step(0, 0, 1, 8'(dut_xfers));
    chk("f1_xfers", dut_xfers, S_ROWS * S_COLS);
    chk("f1_frame_done", fd_cnt, 1);
    chk("f1_underflow", s_uf, 0);
    seg_check("f1_stream");

    // Frame 2: source empty for three window pixels.
    clear_counts();
    p0 = (S_VDS + 2) * S_HT + S_HDS + 4;
    for (int i = 0; i < S_FRAME; i++)
      s_step(0, 0, !(m_pos >= p0 && m_pos < p0 + 3), 8'(dut_xfers));
    chk("f2_xfers", dut_xfers, S_ROWS * S_COLS - 3);
    chk("f2_frame_done", fd_cnt, 1);
    chk("f2_underflow", s_uf, 1);
    seg_check("f2_stream");

    // Frame 3: random source and stray start pulses while running.
    clear_counts();
    for (int i = 0; i < S_FRAME; i++)
      s_step($urandom_range(0, 40) == 0, 0, $urandom_range(0, 7) != 0, 8'($urandom));
    chk("f3_xfers", dut_xfers, m_xfers);
    chk("f3_frame_done", fd_cnt, 1);
    chk("f3_underflow_sticky", s_uf, 1);
    seg_check("f3_stream");

    // Frame 4: stop at line 10, frame runs out to its wrap, then stays idle.
    while (m_pos != 10 * S_HT) s_step(0, 0, 1, 8'($urandom));
    s_step(0, 1, 1, 8'($urandom));
    steps = 1;
    while (s_busy === 1'b1 && steps < 2 * S_FRAME) begin
      s_step($urandom_range(0, 30) == 0, $urandom_range(0, 30) == 0, $urandom_range(0, 1), 8'($urandom));
      steps++;
    end
    chk("stop_cycles_to_idle", steps, S_FRAME - 10 * S_HT);
    chk("stop_busy", s_busy, 0);
    ready_cnt = 0;
    repeat (40) s_step(0, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
    chk("stop_no_ready", ready_cnt, 0);
    chk("stop_HS", s_HS, 1);
    chk("stop_VS", s_VS, 1);
    seg_check("stop_stream");

    // Start and stop together while idle: start wins.
    s_step(1, 1, 1, 8'h11);
    repeat (60) s_step(0, 0, 1, 8'($urandom));
    chk("start_stop_busy", s_busy, 1);
    seg_check("start_stop_stream");

    // Asynchronous reset in the middle of a line.
    while (m_pos != 8 * S_HT + 20) s_step(0, 0, 1, 8'($urandom));
    #2;
    s_rst_n = 0;
    #1;
    chk("mid_rst_R", s_R, 0);       chk("mid_rst_HS", s_HS, 1);    chk("mid_rst_VS", s_VS, 1);
    chk("mid_rst_busy", s_busy, 0); chk("mid_rst_ready", s_if.pix_ready, 0);
    chk("mid_rst_uf", s_uf, 0);     chk("mid_rst_fd", s_fd, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rst_n = 1;
    m_busy = 0; m_pend = 0; m_pos = 0; m_uf = 0;
    ready_cnt = 0;
    repeat (30) s_step(0, $urandom_range(0, 1), 1, 8'($urandom));
    chk("post_rst_no_ready", ready_cnt, 0);
    chk("post_rst_busy", s_busy, 0);
    s_step(1, 0, 1, 8'h22);
    repeat (100) s_step(0, 0, $urandom_range(0, 3) != 0, 8'($urandom));
    chk("restart_busy", s_busy, 1);
    seg_check("restart_stream");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
